// File: rtl/tt_tern_pkg.sv
// tt_tern_pkg: shared ternary-engine types, plane constants and weight indexing.
package tt_tern_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MSB, ST_LSB, ST_CSUM} state_e;
  localparam logic PLANE_MSB = 1'b0;
  localparam logic PLANE_LSB = 1'b1;
  function automatic int flat_idx(input int i, input int c, input int out_len);
    return i * out_len + c;
  endfunction
endpackage

// File: rtl/tt_um_unload_plane_mux.sv
// tt_um_unload_plane_mux: selects one column and bit-plane from the snapshot, masking rows above last_row_i.
module tt_um_unload_plane_mux
  import tt_tern_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int CW          = 3,
  parameter int RW          = 4
) (
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights_i,
  input  logic [CW-1:0]                       col_i,
  input  logic                                plane_i,
  input  logic [RW-1:0]                       last_row_i,
  output logic [MAX_IN_LEN-1:0]               beat_o
);
  for (genvar i = 0; i < MAX_IN_LEN; i++) begin : g_row
    logic [2*MAX_OUT_LEN-1:0] row_w;
    // A row's weights are contiguous, so {col, msb} addresses the bit directly.
    assign row_w = weights_i[2*flat_idx(i, 0, MAX_OUT_LEN) +: 2*MAX_OUT_LEN];
    assign beat_o[i] = row_w[{col_i, plane_i == PLANE_MSB}] & (RW'(i) <= last_row_i);
  end
endmodule

// File: rtl/tt_um_unload.sv
// tt_um_unload: streams a snapshot of the packed ternary weights out as MSB/LSB bit-plane beats per column.
// Defining UNLOAD_CHECKSUM_EN appends an XOR trailer beat after the last column.
module tt_um_unload
  import tt_tern_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ui_start,
  input  logic [6:0]                          ui_param,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
  input  logic                                ui_ready,
  output logic [MAX_IN_LEN-1:0]               uo_output,
  output logic                                uo_valid,
  output logic                                uo_busy,
  output logic                                uo_done
);
  localparam int CW = MAX_OUT_LEN > 1 ? $clog2(MAX_OUT_LEN) : 1;
  localparam int RW = MAX_IN_LEN > 1 ? $clog2(MAX_IN_LEN) : 1;
  localparam int WW = 2 * MAX_IN_LEN * MAX_OUT_LEN;
`ifdef UNLOAD_CHECKSUM_EN
  localparam state_e END_ST = ST_CSUM;
`else
  localparam state_e END_ST = ST_IDLE;
`endif
  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d, last_col_q, last_col_d;
  logic [RW-1:0] last_row_q, last_row_d;
  logic [WW-1:0] snap_q, snap_d;
  logic [MAX_IN_LEN-1:0] out_q, out_d, beat;
  logic active_q, done_q, start_ok, fire, last, plane;
  logic [31:0] c_raw, r_raw;
  assign start_ok = state_q == ST_IDLE && ui_start;
  assign fire = active_q & ui_ready;
  assign last = col_q == last_col_q;
  assign c_raw = {29'd0, ui_param[2:0]};
  assign r_raw = {28'd0, ui_param[6:3]};
  assign snap_d = start_ok ? ui_weights : snap_q;
  assign last_col_d = !start_ok ? last_col_q : c_raw >= MAX_OUT_LEN ? CW'(MAX_OUT_LEN - 1) : CW'(c_raw);
  assign last_row_d = !start_ok ? last_row_q : r_raw >= MAX_IN_LEN ? RW'(MAX_IN_LEN - 1) : RW'(r_raw);
  assign plane = state_d == ST_LSB ? PLANE_LSB : PLANE_MSB;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    unique case (state_q)
      ST_IDLE: state_d = ui_start ? ST_MSB : ST_IDLE;
      ST_MSB:  state_d = fire ? ST_LSB : ST_MSB;
      ST_LSB: begin
        state_d = !fire ? ST_LSB : !last ? ST_MSB : END_ST;
        col_d = (fire && !last) ? col_q + CW'(1) : col_q;
      end
      default: state_d = fire ? ST_IDLE : state_q;
    endcase
    if (start_ok) col_d = '0;
  end
  // Computed from next-state values so the beat register is ready the cycle the state is entered.
  tt_um_unload_plane_mux #(
    .MAX_IN_LEN (MAX_IN_LEN),
    .MAX_OUT_LEN(MAX_OUT_LEN),
    .CW         (CW),
    .RW         (RW)
  ) u_mux (
    .weights_i (snap_d),
    .col_i     (col_d),
    .plane_i   (plane),
    .last_row_i(last_row_d),
    .beat_o    (beat)
  );
`ifdef UNLOAD_CHECKSUM_EN
  logic [MAX_IN_LEN-1:0] csum_q, csum_d;
  assign csum_d = start_ok ? '0 : (fire && state_q != ST_CSUM) ? csum_q ^ out_q : csum_q;
  assign out_d = state_d == ST_CSUM ? csum_d : state_d == ST_IDLE ? '0 : beat;
  always_ff @(posedge clk) csum_q <= csum_d;
`else
  assign out_d = state_d == ST_IDLE ? '0 : beat;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q <= '0;
      out_q <= '0;
      active_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      out_q <= out_d;
      active_q <= state_d != ST_IDLE;
      done_q <= fire && state_d == ST_IDLE;
    end
  end
  // Snapshot and captured parameters survive reset.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    last_col_q <= last_col_d;
    last_row_q <= last_row_d;
  end
  assign uo_output = out_q;
  assign uo_valid = active_q;
  assign uo_busy = active_q;
  assign uo_done = done_q;
endmodule

// File: tb/tb_tt_um_unload.sv
// tb_tt_um_unload: directed scoreboard bench for the weight read-back transmitter.
module tb_tt_um_unload;
`ifdef UNLOAD_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk = 1'b0;
  logic rst, ui_start, ui_ready, uo_valid, uo_busy, uo_done;
  logic [6:0] ui_param;
  logic [255:0] ui_weights;
  logic [15:0] uo_output;
  int checks = 0;
  int failures = 0;
  logic [15:0] q[$];
  logic [15:0] rx[$];
  always #5 clk = ~clk;
  tt_um_unload dut (
    .clk(clk), .rst(rst), .ui_start(ui_start), .ui_param(ui_param),
    .ui_weights(ui_weights), .ui_ready(ui_ready), .uo_output(uo_output),
    .uo_valid(uo_valid), .uo_busy(uo_busy), .uo_done(uo_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Outputs are sampled 1 time unit after the rising edge; a valid beat with ready high is accepted at the next edge.
  task automatic cyc();
    if (uo_valid && ui_ready) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) chk("beat", 32'(uo_output), 32'(q.pop_front()));
      rx.push_back(uo_output);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [6:0] p, input logic [255:0] w);
    ui_param = p;
    ui_weights = w;
    ui_start = 1'b1;
    cyc();
    ui_start = 1'b0;
    ui_weights = ~w;
    ui_param = ~p;
    chk("first_valid", 32'(uo_valid), 32'd1);
    chk("first_busy", 32'(uo_busy), 32'd1);
  endtask
  task automatic run(input int budget, input int stall_n, output int ncyc);
    int nacc = 0;
    int st = stall_n;
    logic [15:0] hv = '0;
    ncyc = 0;
    while (!uo_done && ncyc < budget) begin
      if (nacc == 1 && st > 0) begin
        if (st == stall_n) hv = uo_output;
        else begin
          chk("bp_hold_out", 32'(uo_output), 32'(hv));
          chk("bp_hold_valid", 32'(uo_valid), 32'd1);
        end
        ui_ready = 1'b0;
        st--;
      end else ui_ready = 1'b1;
      if (uo_valid && ui_ready) nacc++;
      cyc();
      ncyc++;
    end
    ui_ready = 1'b1;
    chk("done_seen", 32'(uo_done), 32'd1);
    chk("done_busy", 32'(uo_busy), 32'd0);
    chk("done_valid", 32'(uo_valid), 32'd0);
    chk("sb_drained", 32'(q.size()), 32'd0);
  endtask
  task automatic push_diag(input int last_c);
    for (int c = 0; c <= last_c; c++) begin
      q.push_back(16'(1 << c));
      q.push_back(16'(1 << c));
    end
    if (CS != 0) q.push_back(16'h0000);
  endtask
  initial begin
    logic [255:0] diag, w2;
    int n;
    diag = '0;
    for (int c = 0; c < 8; c++) diag[2*(c*8+c) +: 2] = 2'b11;
    rst = 1'b1;
    ui_start = 1'b1;
    ui_ready = 1'b1;
    ui_param = 7'h7F;
    ui_weights = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(uo_output), 32'd0);
    chk("rst_valid", 32'(uo_valid), 32'd0);
    chk("rst_busy", 32'(uo_busy), 32'd0);
    chk("rst_done", 32'(uo_done), 32'd0);
    rst = 1'b0;
    ui_start = 1'b0;
    cyc();
    chk("post_rst_valid", 32'(uo_valid), 32'd0);
    chk("post_rst_busy", 32'(uo_busy), 32'd0);
    // Single column, all weights +1.
    q.push_back(16'h0000);
    q.push_back(16'hFFFF);
    if (CS != 0) q.push_back(16'hFFFF);
    start({4'd15, 3'd0}, {128{2'b01}});
    run(50, 0, n);
    chk("single_cycles", 32'(n), 32'(2 + CS));
    cyc();
    chk("done_pulse_width", 32'(uo_done), 32'd0);
    // Full diagonal array, reconstructed from the stream.
    rx.delete();
    push_diag(7);
    start({4'd15, 3'd7}, diag);
    run(100, 0, n);
    chk("full_cycles", 32'(n), 32'(16 + CS));
    w2 = '0;
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 16; i++) begin
        w2[2*(i*8+c)+1] = rx[2*c][i];
        w2[2*(i*8+c)]   = rx[2*c+1][i];
      end
    checks++;
    assert (w2 === diag) else begin
      failures++;
      $error("FAIL reconstruct observed=%h expected=%h", w2, diag);
    end
    // Row mask R=3, all weights -1; started in the done cycle.
    for (int k = 0; k < 6; k++) q.push_back(16'h000F);
    if (CS != 0) q.push_back(16'h0000);
    start({4'd3, 3'd2}, {128{2'b11}});
    run(50, 0, n);
    chk("mask_cycles", 32'(n), 32'(6 + CS));
    // Backpressure on the second beat.
    push_diag(7);
    start({4'd15, 3'd7}, diag);
    run(100, 4, n);
    chk("bp_cycles", 32'(n), 32'(20 + CS));
    // Abort on the third beat, then restart from column 0.
    push_diag(7);
    start({4'd15, 3'd7}, diag);
    cyc();
    cyc();
    chk("abort_third", 32'(uo_output), 32'h0002);
    rst = 1'b1;
    cyc();
    q.delete();
    chk("abort_out", 32'(uo_output), 32'd0);
    chk("abort_valid", 32'(uo_valid), 32'd0);
    chk("abort_busy", 32'(uo_busy), 32'd0);
    chk("abort_done", 32'(uo_done), 32'd0);
    rst = 1'b0;
    cyc();
    push_diag(1);
    start({4'd15, 3'd1}, diag);
    chk("restart_col0", 32'(uo_output), 32'h0001);
    run(50, 0, n);
    chk("restart_cycles", 32'(n), 32'(4 + CS));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_unload.md
# tt_um_unload

Weight read-back transmitter for the ternary matrix engine. It snapshots the packed 2-bit signed weight array held by the loader, then streams it out one column at a time as two bit-plane beats: sign/MSB plane first, LSB plane second. The beat format is exactly the one the loader accepts on its input bus. The block sits beside the loader on the tile's shared dedicated I/O and is used for weight verification and chip-to-chip weight forwarding.

## Interface
- `MAX_IN_LEN`, default 16: rows per column; also the beat width.
- `MAX_OUT_LEN`, default 8: number of columns.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ui_start`  in  1  request a read-back; sampled only in IDLE.
- `ui_param`  in  7  `[2:0]` = last column index C; `[6:3]` = last row index R. Captured at start.
- `ui_weights`  in  `2*MAX_IN_LEN*MAX_OUT_LEN`  packed weights. Weight (row i, col c) occupies bits `[2*(i*MAX_OUT_LEN+c)+1 : 2*(i*MAX_OUT_LEN+c)]`.
- `ui_ready`  in  1  downstream accepts the current beat.
- `uo_output`  out  `MAX_IN_LEN`  beat data.
- `uo_valid`  out  1  beat data is valid.
- `uo_busy`  out  1  a transfer is in progress (any state other than IDLE).
- `uo_done`  out  1  one-cycle pulse on the cycle after the final beat is accepted.

## Operation
- States: IDLE, MSB, LSB (and CSUM when `UNLOAD_CHECKSUM_EN` is defined).
- IDLE with `ui_start`=1:
  - snapshot `ui_weights` into an internal register and capture `ui_param`;
  - reset column counter `col` to 0;
  - go to MSB.
- MSB: `uo_output[i]` = bit 1 of snapshot weight (i, `col`) for i ≤ R; 0 for i > R.
- LSB: same mapping, using bit 0 of each weight.
- A beat completes only on a cycle with `uo_valid & ui_ready`. Otherwise state, `uo_output` and `uo_valid` hold unchanged.
- On completion:
  - MSB → LSB.
  - LSB with `col` < C → increment `col`, go to MSB.
  - LSB with `col` == C → IDLE, or CSUM when the checksum is compiled in.
- Total beats = 2·(C+1); there is no wrap. If C ≥ `MAX_OUT_LEN`, the transfer stops after column `MAX_OUT_LEN-1`.
- `ui_start` is ignored outside IDLE. Changes to `ui_weights` or `ui_param` during a transfer have no effect.
- R ≥ `MAX_IN_LEN` is treated as `MAX_IN_LEN-1`.
- `rst` asserted in any state:
  - next state IDLE, `col`=0;
  - `uo_valid`, `uo_busy`, `uo_done` = 0 and `uo_output`=0;
  - the snapshot is not cleared.

## Timing
- Reset values: `uo_output`=0, `uo_valid`=0, `uo_busy`=0, `uo_done`=0.
- All outputs are registered.
- `ui_start` sampled in cycle T → `uo_valid`=1 with the first MSB beat in cycle T+1.
- With `ui_ready` held at 1, one beat per cycle with no bubbles; the last beat is in cycle T+2(C+1).
- `uo_done` is high for exactly one cycle, the cycle after the final beat is accepted. In that same cycle `uo_busy`=0 and `uo_valid`=0.
- A new `ui_start` is accepted in that same `uo_done` cycle.

## Configuration
- `UNLOAD_CHECKSUM_EN` defined:
  - after the last LSB beat, the CSUM state emits one extra beat;
  - its value is the bitwise XOR of all data beats sent in this transfer;
  - the beat follows the same `ui_ready` handshake;
  - `uo_done` follows acceptance of this beat.
- `UNLOAD_CHECKSUM_EN` undefined: there is no CSUM state and no accumulator register. `uo_done` follows acceptance of the last LSB beat.

## Structure
- Shared package `tt_tern_pkg` holds:
  - the state enum (IDLE/MSB/LSB/CSUM);
  - plane constants MSB=0 and LSB=1, shared with the loader;
  - the function computing the flat weight index `i*MAX_OUT_LEN+c`.
- One sub-module, `tt_um_unload_plane_mux`: combinational; selects one column and one bit-plane from the snapshot and applies the row mask R.

## Test plan
- **Reset:** hold `rst` 3 cycles, with `ui_start`=1 asserted during reset → all outputs 0 and no transfer begins.
- **Single column:** C=0, R=15, all weights = +1 (01), `ui_ready`=1 → beats 0x0000 then 0xFFFF, then `uo_done` pulses; 2 valid cycles total.
- **Full array:** C=7, R=15, weight (i,c) = −1 (11) when i==c, otherwise 0 → 16 beats. Column c produces MSB = LSB = 1<<c. Feed the stream to the loader and verify `uo_weights` matches the source array.
- **Row mask:** R=3, all weights = −1 → every beat = 0x000F.
- **Backpressure:** deassert `ui_ready` for 4 cycles on the second beat → `uo_output` and `uo_valid` stable throughout, no beat skipped, `uo_done` delayed by 4 cycles.
- **Abort and checksum:**
  - Assert `rst` on the third beat → next cycle IDLE with outputs 0. A restart then begins again at column 0.
  - With `UNLOAD_CHECKSUM_EN`: the trailer beat equals the XOR of the preceding beats (0x0000 for the diagonal array above).
